bcd_to_bin: RTL



---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_sub3.sv | 9 +
 rtl/bcd_to_bin.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: digits >= 8 after a right shift lose 3.
module bcd_digit_sub3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Multi-cycle packed-BCD to binary converter with valid/ready on both sides
// and a flag for non-decimal digits.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter  int unsigned DIGITS = 2,
  localparam int unsigned BIN_W  = $clog2(10 ** DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   sh_bcd;
  logic [BCD_W-1:0]   corr_bcd;
  logic [BIN_W-1:0]   sh_bin;
  logic               any_bad;

  // One-bit right shift of {bcd, bin}; the bcd LSB moves into the bin MSB.
  assign sh_bcd = {1'b0, bcd_q[BCD_W-1:1]};
  assign sh_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
    bcd_digit_sub3 u_sub3 (
      .d_i (sh_bcd[4*g +: 4]),
      .d_o (corr_bcd[4*g +: 4])
    );
  end

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      any_bad = any_bad | digit_invalid(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    bin_out_d   = bin_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (any_bad) begin
          bin_out_d   = '0;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          err_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = corr_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_out_d   = sh_bin;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      bin_out_q   <= bin_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;
  assign err       = err_q;

endmodule
